// File: rtl/char_buffer_if.sv
// Character write stream and clear handshake between the text source and char_buffer.
interface char_buffer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_char;
    logic       clr_req;
    logic       busy;

    modport master (output wr_valid, wr_char, clr_req, input wr_ready, busy);
    modport slave  (input wr_valid, wr_char, clr_req, output wr_ready, busy);
endinterface

// File: rtl/char_buffer.sv
// COLS x ROWS writable text buffer with hardware cursor, CR/LF and clear sweep.
// Define CHAR_BUFFER_LINE_CLEAR_EN to blank each newly entered row (LCLR state).
module char_buffer #(
    parameter  int COLS = 16,
    parameter  int ROWS = 16,
    localparam int XW   = $clog2(COLS),
    localparam int YW   = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    char_buffer_if.slave        wr,
    input  logic [XW+YW-1:0]    char_xy,
    output logic [6:0]          char_code,
    output logic [XW-1:0]       cur_x,
    output logic [YW-1:0]       cur_y
);
    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N);
    localparam int IW = XW + YW + 1;
    localparam logic [IW-1:0] COLS_I    = IW'(COLS);
    localparam logic [IW-1:0] N_I       = IW'(N);
    localparam logic [IW-1:0] LAST_CELL = IW'(N - 1);
    localparam logic [IW-1:0] LAST_COL  = IW'(COLS - 1);
    localparam logic [XW-1:0] XMAX      = XW'(COLS - 1);
    localparam logic [YW-1:0] YMAX      = YW'(ROWS - 1);
    localparam logic [6:0]    SPACE     = 7'h20;

`ifdef CHAR_BUFFER_LINE_CLEAR_EN
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LCLR} state_t;
`else
    typedef enum logic {S_CLEAR, S_IDLE} state_t;
`endif

    state_t        state_q, state_d;
    logic [IW-1:0] sweep_q, sweep_d;
    logic [XW-1:0] cur_x_q, cur_x_d;
    logic [YW-1:0] cur_y_q, cur_y_d;
    logic [6:0]    char_code_q, char_code_d;

    logic [6:0]    mem [N];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [6:0]    mem_wdata;

    logic          accept, row_adv, printable;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [IW-1:0] rd_idx;
    logic          x_ok, rd_ok;

    assign wr.wr_ready = (state_q == S_IDLE) && !wr.clr_req;
    assign wr.busy     = (state_q != S_IDLE);
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign printable   = (wr.wr_char >= 8'h20) && (wr.wr_char <= 8'h7E);

    assign char_code = char_code_q;
    assign cur_x     = cur_x_q;
    assign cur_y     = cur_y_q;

    // Full-width index: with x in range, idx < N holds exactly when y < ROWS.
    assign rd_x   = char_xy[XW+YW-1:YW];
    assign rd_y   = char_xy[YW-1:0];
    assign rd_idx = IW'(rd_y) * COLS_I + IW'(rd_x);
    generate
        if ((2 ** XW) == COLS) begin : g_x_pow2
            assign x_ok = 1'b1;
        end else begin : g_x_npow2
            assign x_ok = (rd_x <= XMAX);
        end
    endgenerate
    assign rd_ok = x_ok && (rd_idx < N_I);

    always_comb begin
        char_code_d = SPACE;
        if (rd_ok) char_code_d = mem[AW'(rd_idx)];
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = SPACE;
        row_adv   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(sweep_q);
                if (sweep_q == LAST_CELL) begin
                    state_d = S_IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (wr.clr_req) begin
                    state_d = S_CLEAR;
                    sweep_d = '0;
                    cur_x_d = '0;
                    cur_y_d = '0;
                end else if (accept) begin
                    if (printable) begin
                        mem_we    = 1'b1;
                        mem_waddr = AW'(IW'(cur_y_q) * COLS_I + IW'(cur_x_q));
                        mem_wdata = wr.wr_char[6:0];
                        if (cur_x_q == XMAX) begin
                            cur_x_d = '0;
                            row_adv = 1'b1;
                        end else begin
                            cur_x_d = cur_x_q + 1'b1;
                        end
                    end else if (wr.wr_char == 8'h0A) begin
                        cur_x_d = '0;
                        row_adv = 1'b1;
                    end else if (wr.wr_char == 8'h0D) begin
                        cur_x_d = '0;
                    end
                    if (row_adv) begin
                        cur_y_d = (cur_y_q == YMAX) ? '0 : cur_y_q + 1'b1;
`ifdef CHAR_BUFFER_LINE_CLEAR_EN
                        state_d = S_LCLR;
                        sweep_d = '0;
`endif
                    end
                end
            end
`ifdef CHAR_BUFFER_LINE_CLEAR_EN
            // cur_y_q already holds the new row when LCLR starts.
            S_LCLR: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(IW'(cur_y_q) * COLS_I + sweep_q);
                if (sweep_q == LAST_COL) begin
                    state_d = S_IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            sweep_q     <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            char_code_q <= 7'h00;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            char_code_q <= char_code_d;
        end
    end

    // Storage is not reset; the clear sweep defines its contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
endmodule

// File: tb/tb_char_buffer.sv
// Directed self-checking bench for char_buffer at default 16x16 geometry.
`timescale 1ns/1ps
module tb_char_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_xy;
    logic [6:0] char_code;
    logic [3:0] cur_x, cur_y;
    int total = 0;
    int bad = 0;

    char_buffer_if bus();

    char_buffer #(.COLS(16), .ROWS(16)) dut (
        .clk(clk), .rst(rst), .wr(bus.slave), .char_xy(char_xy),
        .char_code(char_code), .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int x, input int y, output logic [6:0] code);
        logic [3:0] xx, yy;
        xx = 4'(x);
        yy = 4'(y);
        char_xy = {xx, yy};
        tick();
        code = char_code;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.wr_ready && n < 1000) begin
            tick();
            n++;
        end
    endtask

    // Offers one character; stalls (bounded) until accepted; waited = stall cycles.
    task automatic send(input logic [7:0] ch, output int waited);
        bus.wr_valid = 1'b1;
        bus.wr_char  = ch;
        waited = 0;
        while (!bus.wr_ready && waited < 100) begin
            tick();
            waited++;
        end
        total++;
        if (!bus.wr_ready) begin
            bad++;
            $display("FAIL send_timeout char=%h waited=%0d", ch, waited);
        end
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n, errs;
        logic [6:0] c;
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_char  = 8'h00;
        bus.clr_req  = 1'b0;
        char_xy      = 8'h00;
        repeat (3) tick();
        total++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags busy=%b ready=%b exp busy=1 ready=0", bus.busy, bus.wr_ready);
        end
        total++;
        if (char_code !== 7'h00 || cur_x !== 4'd0 || cur_y !== 4'd0) begin
            bad++;
            $display("FAIL reset_values code=%h cur=(%0d,%0d) exp 00 (0,0)", char_code, cur_x, cur_y);
        end
        rst = 1'b0;
        wait_ready(n);
        total++;
        if (n !== 256) begin
            bad++;
            $display("FAIL reset_sweep_len got=%0d exp=256", n);
        end
        errs = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                rd(x, y, c);
                if (c !== 7'h20) errs++;
            end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL reset_cells_blank nonblank=%0d exp=0", errs);
        end
    endtask

    task automatic test_hi();
        int w0, w1;
        logic [6:0] c;
        send(8'h48, w0);
        send(8'h69, w1);
        total++;
        if (w0 !== 0 || w1 !== 0) begin
            bad++;
            $display("FAIL hi_throughput stalls=%0d,%0d exp 0,0", w0, w1);
        end
        total++;
        if (cur_x !== 4'd2 || cur_y !== 4'd0) begin
            bad++;
            $display("FAIL hi_cursor got=(%0d,%0d) exp=(2,0)", cur_x, cur_y);
        end
        rd(0, 0, c);
        total++;
        if (c !== 7'h48) begin
            bad++;
            $display("FAIL hi_cell0 got=%h exp=48", c);
        end
        rd(1, 0, c);
        total++;
        if (c !== 7'h69) begin
            bad++;
            $display("FAIL hi_cell1 got=%h exp=69", c);
        end
    endtask

    task automatic test_wrap_row();
        int w, errs;
        logic [6:0] c;
        send(8'h0D, w);
        total++;
        if (cur_x !== 4'd0 || cur_y !== 4'd0) begin
            bad++;
            $display("FAIL cr_cursor got=(%0d,%0d) exp=(0,0)", cur_x, cur_y);
        end
        repeat (17) send(8'h41, w);
        total++;
        if (cur_x !== 4'd1 || cur_y !== 4'd1) begin
            bad++;
            $display("FAIL wrap_cursor got=(%0d,%0d) exp=(1,1)", cur_x, cur_y);
        end
        errs = 0;
        for (int x = 0; x < 16; x++) begin
            rd(x, 0, c);
            if (c !== 7'h41) errs++;
        end
        rd(0, 1, c);
        if (c !== 7'h41) errs++;
        rd(1, 1, c);
        if (c !== 7'h20) errs++;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL wrap_cells wrong=%0d exp=0", errs);
        end
    endtask

    task automatic test_newline_wrap();
        int w, n;
        logic [6:0] c;
        send(8'h0D, w);
        repeat (14) send(8'h0A, w);
        repeat (5) send(8'h42, w);
        total++;
        if (cur_x !== 4'd5 || cur_y !== 4'd15) begin
            bad++;
            $display("FAIL lf_setup_cursor got=(%0d,%0d) exp=(5,15)", cur_x, cur_y);
        end
        send(8'h0A, w);
        total++;
        if (cur_x !== 4'd0 || cur_y !== 4'd0) begin
            bad++;
            $display("FAIL lf_wrap_cursor got=(%0d,%0d) exp=(0,0)", cur_x, cur_y);
        end
`ifdef CHAR_BUFFER_LINE_CLEAR_EN
        wait_ready(n);
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL lclr_stall got=%0d exp=16", n);
        end
        rd(3, 0, c);
        total++;
        if (c !== 7'h20) begin
            bad++;
            $display("FAIL lclr_row0 got=%h exp=20", c);
        end
`else
        n = 0;
        total++;
        if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL lf_no_stall ready=%b busy=%b exp 1,0", bus.wr_ready, bus.busy);
        end
        rd(3, 0, c);
        total++;
        if (c !== 7'h41) begin
            bad++;
            $display("FAIL lf_row0_kept got=%h exp=41", c);
        end
`endif
    endtask

    task automatic test_clear();
        int w, n;
        logic [6:0] c;
        send(8'h51, w);
        bus.clr_req  = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_char  = 8'h5A;
        #1;
        total++;
        if (bus.wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_ready_low got=%b exp=0", bus.wr_ready);
        end
        tick();
        bus.clr_req  = 1'b0;
        bus.wr_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || cur_x !== 4'd0 || cur_y !== 4'd0) begin
            bad++;
            $display("FAIL clr_start busy=%b cur=(%0d,%0d) exp 1 (0,0)", bus.busy, cur_x, cur_y);
        end
        n = 10;
        repeat (10) tick();
        rd(0, 15, c);
        n++;
        total++;
        if (c !== 7'h42) begin
            bad++;
            $display("FAIL clr_partial_old got=%h exp=42", c);
        end
        rd(0, 0, c);
        n++;
        total++;
        if (c !== 7'h20) begin
            bad++;
            $display("FAIL clr_partial_new got=%h exp=20", c);
        end
        while (!bus.wr_ready && n < 1000) begin
            tick();
            n++;
        end
        total++;
        if (n !== 256) begin
            bad++;
            $display("FAIL clr_sweep_len got=%0d exp=256", n);
        end
        rd(1, 0, c);
        total++;
        if (c !== 7'h20 || cur_x !== 4'd0 || cur_y !== 4'd0) begin
            bad++;
            $display("FAIL clr_z_dropped cell=%h cur=(%0d,%0d) exp 20 (0,0)", c, cur_x, cur_y);
        end
    endtask

    task automatic test_illegal();
        int w, ws;
        logic [6:0] c;
        send(8'h43, w);
        ws = 0;
        send(8'h07, w); ws += w;
        send(8'h80, w); ws += w;
        send(8'h7F, w); ws += w;
        send(8'hC1, w); ws += w;
        total++;
        if (ws !== 0 || cur_x !== 4'd1 || cur_y !== 4'd0) begin
            bad++;
            $display("FAIL illegal_consumed stalls=%0d cur=(%0d,%0d) exp 0 (1,0)", ws, cur_x, cur_y);
        end
        rd(1, 0, c);
        total++;
        if (c !== 7'h20) begin
            bad++;
            $display("FAIL illegal_no_write got=%h exp=20", c);
        end
        rd(0, 0, c);
        total++;
        if (c !== 7'h43) begin
            bad++;
            $display("FAIL illegal_keep got=%h exp=43", c);
        end
        send(8'h7E, w);
        rd(1, 0, c);
        total++;
        if (c !== 7'h7E || cur_x !== 4'd2) begin
            bad++;
            $display("FAIL tilde_edge cell=%h x=%0d exp 7e 2", c, cur_x);
        end
    endtask

    task automatic test_rst_mid_sweep();
        int n;
        logic [6:0] c;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b1 || char_code !== 7'h00 || cur_x !== 4'd0 || cur_y !== 4'd0) begin
            bad++;
            $display("FAIL rst_mid busy=%b code=%h cur=(%0d,%0d) exp 1 00 (0,0)", bus.busy, char_code, cur_x, cur_y);
        end
        tick();
        tick();
        rst = 1'b0;
        wait_ready(n);
        total++;
        if (n !== 256) begin
            bad++;
            $display("FAIL rst_mid_sweep_len got=%0d exp=256", n);
        end
        rd(0, 15, c);
        total++;
        if (c !== 7'h20) begin
            bad++;
            $display("FAIL rst_mid_tail got=%h exp=20", c);
        end
    endtask

    initial begin
        test_reset();
        test_hi();
        test_wrap_row();
        test_newline_wrap();
        test_clear();
        test_illegal();
        test_rst_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/char_buffer.md
# char_buffer

Writable, parametrised character buffer for the VGA text overlay. It replaces the fixed-string ROM with a COLS×ROWS RAM filled through a valid/ready character stream. It keeps a hardware cursor, handles newline and carriage return, and can clear itself. The renderer reads it with the same {x,y} packed address and 1-cycle registered latency as the ROM it supersedes.

## Interface
Parameters:
- COLS, 16, characters per row (≥2)
- ROWS, 16, rows (≥2)
- XW, $clog2(COLS), column address width (derived, not overridden)
- YW, $clog2(ROWS), row address width (derived, not overridden)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  write character offered
- wr_ready  out  1  buffer accepts a character this cycle
- wr_char  in  8  ASCII character
- clr_req  in  1  single-cycle request to clear the whole buffer
- busy  out  1  high while a clear sweep runs
- char_xy  in  XW+YW  read address, x in [XW+YW-1:YW], y in [YW-1:0]
- char_code  out  7  registered character at char_xy
- cur_x  out  XW  cursor column
- cur_y  out  YW  cursor row

## Operation
- Storage is a COLS*ROWS×7 RAM at index y*COLS+x. It has no reset; contents are defined only by the clear sweep.
- FSM states:
  - CLEAR (reset state): writes 0x20 to index 0..COLS*ROWS-1, one cell per cycle, then goes to IDLE.
  - IDLE: accepts writes.
  - LCLR: line clear, only with the macro enabled.
- wr_ready = (state==IDLE) && !clr_req. A transfer happens when wr_valid && wr_ready.
- clr_req in IDLE: enter CLEAR and home the cursor to (0,0). If clr_req and wr_valid coincide, the clear wins and the character is not consumed. clr_req is ignored outside IDLE.
- busy = (state==CLEAR) || (state==LCLR).
- Accepted character handling:
  - 0x20..0x7E: write wr_char[6:0] at (cur_x,cur_y), then advance cur_x. Past COLS-1: cur_x=0 and the row advances.
  - 0x0A: cur_x=0, row advance.
  - 0x0D: cur_x=0, row unchanged.
  - Anything else, including bit 7 set: consumed, no RAM write, cursor unchanged.
- Row advance: cur_y+1, wrapping ROWS-1→0.
- Read port:
  - char_code <= RAM[index] for in-range x<COLS and y<ROWS.
  - Out-of-range coordinates (x≥COLS or y≥ROWS when not a power of two) return 0x20.
  - Same-cycle read and write of one cell returns the old value (read-first).
- Index arithmetic is done at XW+YW+1 bits; no truncation before the range check.

## Timing
- Reset values: state=CLEAR, sweep counter=0, cur_x=0, cur_y=0, char_code=7'h00, busy=1, wr_ready=0.
- The first rising edge after rst deasserts writes index 0. The full sweep takes COLS*ROWS cycles. wr_ready rises the cycle after the last cell is written (256 cycles after reset release at defaults).
- A write completes in one cycle. The next character can be accepted the following cycle, so full throughput is 1 char/clk.
- Cursor outputs update the cycle after acceptance.
- Read latency is exactly 1 clk from char_xy to char_code. The read port operates in every state, including during a sweep, and shows partially cleared contents.
- rst asserted mid-sweep or mid-write immediately forces CLEAR and restarts the sweep from index 0.

## Configuration
- CHAR_BUFFER_LINE_CLEAR_EN defined:
  - Every row advance (wrap, 0x0A, or ROWS-1→0) enters LCLR.
  - LCLR writes 0x20 to the COLS cells of the new cur_y, one per cycle, with wr_ready=0 and busy=1, then returns to IDLE.
  - clr_req is ignored during LCLR.
- Undefined: no LCLR state. A row advance leaves old row contents in place, and wr_ready stays high.

## Test plan
- Reset release, defaults: busy=1 for 256 cycles. All reads of (0..15,0..15) then return 0x20. wr_ready=1 at cycle 257.
- Stream "Hi" then read (0,0),(1,0): char_code 0x48 and 0x69 one clk after each address. cur_x=2, cur_y=0.
- 17 × 'A' at cur (0,0): cells (0..15,0) and (0,1) hold 0x41. Final cursor is (1,1).
- Cursor at (5,15), send 0x0A: cursor becomes (0,0). With LINE_CLEAR_EN, row 0 reads 0x20 and wr_ready is low for 16 cycles. Without it, row 0 keeps its old data and there is no stall.
- clr_req together with wr_valid='Z' in IDLE: 'Z' is not written, the sweep runs for 256 cycles, and the cursor is (0,0).
- Send 0x07 and 0x80: both consumed with wr_ready=1, no cell changes, cursor unchanged. Also assert rst mid-sweep at count 100: the sweep restarts and completes 256 cycles after release.
